tmds_lock_ctrl: RTL and testbench

Link-training supervisor for the three-channel HDMI/TMDS receive path. It sequences the per-channel decoders through reset, word alignment and channel bonding. It then supervises the locked link and retrains on loss or alignment error. It sits beside the three channel decoders in the HDMI-in top level: it drives their shared `prst`, and consumes each channel's valid, ready, align-error and vde outputs.

---
 rtl/tmds_rx_pkg.sv | 18 +
 rtl/tmds_lock_timer.sv | 32 +++
 rtl/tmds_lock_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_tmds_lock_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_rx_pkg.sv
// rtl/tmds_rx_pkg.sv - shared types and constants for the TMDS receive path
package tmds_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_BOND   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } lock_state_t;

    localparam int kNumCh   = 3;
    localparam int kChBlue  = 0;
    localparam int kChGreen = 1;
    localparam int kChRed   = 2;

endpackage

// File: rtl/tmds_lock_timer.sv
// rtl/tmds_lock_timer.sv - loadable up-counter with terminal-count compare
module tmds_lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Clear wins over load, load wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/tmds_lock_ctrl.sv
// rtl/tmds_lock_ctrl.sv - link-training supervisor for the three TMDS channel decoders
module tmds_lock_ctrl
    import tmds_rx_pkg::*;
#(
    parameter int kRstCycles    = 16,
    parameter int kAlignTimeout = 1048576,
    parameter int kStableCycles = 256,
    parameter int kMaxRetries   = 7,
    parameter int kVdeErrMax    = 4
) (
    input  logic              pixelclk,
    input  logic              arst,
    input  logic              enable,
    input  logic [kNumCh-1:0] pvld,
    input  logic [kNumCh-1:0] prdy,
    input  logic [kNumCh-1:0] palignerr,
    input  logic [kNumCh-1:0] pvde,
    output logic              prst,
    output logic              locked,
    output logic              lock_lost,
    output logic              fail,
    output logic [3:0]        retry_cnt,
    output logic [2:0]        state
);

    localparam int TW = $clog2(kAlignTimeout + 1);
    localparam int SW = $clog2(kStableCycles + 1);
    localparam int VW = $clog2(kVdeErrMax + 1);

    // The timeout timer is preloaded with 1 so its value equals the ALIGN/BOND cycle number.
    localparam logic [TW-1:0] lp_rst_last    = TW'(kRstCycles - 1);
    localparam logic [TW-1:0] lp_timeout     = TW'(kAlignTimeout);
    localparam logic [TW-1:0] lp_tmr_first   = TW'(1);
    localparam logic [SW-1:0] lp_stable_last = SW'(kStableCycles - 1);
    localparam logic [VW-1:0] lp_vde_last    = VW'(kVdeErrMax - 1);
    localparam logic [3:0]    lp_max_retries = 4'(kMaxRetries);

    lock_state_t   r_state;
    logic          r_prst;
    logic          r_locked;
    logic          r_lock_lost;
    logic          r_fail;
    logic [3:0]    r_retry_cnt;
    logic [VW-1:0] r_vde_cnt;

    logic          w_all_vld;
    logic          w_all_rdy;
    logic          w_any_err;
    logic          w_vde_mismatch;
    logic          w_in_training;
    logic          w_tmr_clr;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_term;
    logic          w_tmr_tc;
    logic          w_rst_done;
    logic          w_timeout;
    logic          w_stab_clr;
    logic          w_stab_tc;
    logic          w_stable_done;
    logic          w_vde_loss;
    logic          w_lock_loss;
    logic          w_retry;
    logic [3:0]    w_retry_next;

    assign w_all_vld = pvld[kChBlue] & pvld[kChGreen] & pvld[kChRed];
    assign w_all_rdy = prdy[kChBlue] & prdy[kChGreen] & prdy[kChRed];
    assign w_any_err = |palignerr;
    assign w_vde_mismatch = (pvde[kChBlue] != pvde[kChGreen]) ||
                            (pvde[kChGreen] != pvde[kChRed]);

    assign w_in_training = (r_state == ST_RESET) || (r_state == ST_ALIGN) ||
                           (r_state == ST_BOND);

    // One timer serves both the RESET hold and the ALIGN/BOND timeout.
    assign w_tmr_term = (r_state == ST_RESET) ? lp_rst_last : lp_timeout;
    assign w_rst_done = (r_state == ST_RESET) && w_tmr_tc;
    assign w_timeout  = ((r_state == ST_ALIGN) || (r_state == ST_BOND)) && w_tmr_tc;

    assign w_stable_done = w_all_rdy && w_stab_tc;
    assign w_vde_loss    = w_vde_mismatch && (r_vde_cnt == lp_vde_last);
    assign w_lock_loss   = !w_all_vld || !w_all_rdy || w_any_err || w_vde_loss;

    assign w_retry = enable &&
        (((r_state == ST_ALIGN) && (w_any_err || (!w_all_vld && w_timeout))) ||
         ((r_state == ST_BOND) &&
          (w_any_err || !w_all_vld || (!w_stable_done && w_timeout))));

    assign w_retry_next = (r_retry_cnt == 4'hF) ? 4'hF : (r_retry_cnt + 4'd1);

    assign w_tmr_clr  = w_retry || !w_in_training;
    assign w_tmr_load = w_rst_done;
    assign w_stab_clr = !((r_state == ST_BOND) && w_all_rdy);

    tmds_lock_timer #(
        .W (TW)
    ) u_tmr (
        .clk        (pixelclk),
        .rst        (arst),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (lp_tmr_first),
        .i_en       (w_in_training),
        .i_term     (w_tmr_term),
        .o_tc       (w_tmr_tc)
    );

    tmds_lock_timer #(
        .W (SW)
    ) u_stable (
        .clk        (pixelclk),
        .rst        (arst),
        .i_clr      (w_stab_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (1'b1),
        .i_term     (lp_stable_last),
        .o_tc       (w_stab_tc)
    );

    // Consecutive-cycle count of vde disagreement while the link is locked.
    always_ff @(posedge pixelclk or posedge arst) begin
        if (arst) begin
            r_vde_cnt <= '0;
        end else if (enable && (r_state == ST_LOCKED) && w_vde_mismatch) begin
            r_vde_cnt <= r_vde_cnt + 1'b1;
        end else begin
            r_vde_cnt <= '0;
        end
    end

    // Training FSM with registered status outputs; enable=0 overrides everything.
    always_ff @(posedge pixelclk or posedge arst) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_prst      <= 1'b1;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
            r_retry_cnt <= 4'd0;
        end else begin
            r_lock_lost <= 1'b0;
            if (!enable) begin
                r_state  <= ST_IDLE;
                r_prst   <= 1'b1;
                r_locked <= 1'b0;
                r_fail   <= 1'b0;
            end else if (w_retry) begin
                r_retry_cnt <= w_retry_next;
                r_prst      <= 1'b1;
                if (w_retry_next == lp_max_retries) begin
                    r_state <= ST_FAIL;
                    r_fail  <= 1'b1;
                end else begin
                    r_state <= ST_RESET;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_RESET;
                        r_retry_cnt <= 4'd0;
                        r_prst      <= 1'b1;
                    end
                    ST_RESET: begin
                        if (w_rst_done) begin
                            r_state <= ST_ALIGN;
                            r_prst  <= 1'b0;
                        end
                    end
                    ST_ALIGN: begin
                        if (w_all_vld) begin
                            r_state <= ST_BOND;
                        end
                    end
                    ST_BOND: begin
                        if (w_stable_done) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_lock_loss) begin
                            r_state     <= ST_RESET;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_prst      <= 1'b1;
                            r_retry_cnt <= 4'd0;
                        end
                    end
                    ST_FAIL: begin
                        r_state <= ST_FAIL;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_prst   <= 1'b1;
                        r_locked <= 1'b0;
                        r_fail   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign prst      = r_prst;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;
    assign fail      = r_fail;
    assign retry_cnt = r_retry_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_tmds_lock_ctrl.sv
// tb/tb_tmds_lock_ctrl.sv - directed scoreboard bench for tmds_lock_ctrl
module tb_tmds_lock_ctrl;

    logic       pixelclk = 1'b0;
    logic       arst;
    logic       enable;
    logic [2:0] pvld;
    logic [2:0] prdy;
    logic [2:0] palignerr;
    logic [2:0] pvde;
    logic       prst;
    logic       locked;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    tmds_lock_ctrl #(
        .kRstCycles    (4),
        .kAlignTimeout (100),
        .kStableCycles (8),
        .kMaxRetries   (3),
        .kVdeErrMax    (4)
    ) dut (
        .pixelclk  (pixelclk),
        .arst      (arst),
        .enable    (enable),
        .pvld      (pvld),
        .prdy      (prdy),
        .palignerr (palignerr),
        .pvde      (pvde),
        .prst      (prst),
        .locked    (locked),
        .lock_lost (lock_lost),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        string  tag;
        integer exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_lost_hi = 0;
    int   n_excl = 0;
    int   t_a, t_b, t_c, t_d;

    always @(negedge pixelclk) begin
        if (lock_lost === 1'b1) n_lost_hi++;
        if ((int'(locked) + int'(fail) + int'(lock_lost)) > 1) n_excl++;
    end

    task automatic step();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic expect_val(input string tag, input integer exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check_obs(input integer obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arst = 1'b1; enable = 1'b0; pvld = 3'b000; prdy = 3'b000;
        palignerr = 3'b000; pvde = 3'b000;

        // reset values
        expect_val("rst_state", 0); expect_val("rst_prst", 1); expect_val("rst_locked", 0);
        expect_val("rst_lock_lost", 0); expect_val("rst_fail", 0); expect_val("rst_retry", 0);
        repeat (3) step();
        check_obs(int'(state)); check_obs(int'(prst)); check_obs(int'(locked));
        check_obs(int'(lock_lost)); check_obs(int'(fail)); check_obs(int'(retry_cnt));
        expect_val("idle_after_rst", 0);
        arst = 1'b0;
        step();
        check_obs(int'(state));

        // clean lock
        expect_val("clean_prst_fall", 5); expect_val("clean_lock_rise", 20);
        expect_val("clean_retry", 0);
        t_a = -1; t_b = -1;
        enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) pvld = 3'b111;
            if (c == 12) prdy = 3'b111;
            step();
            if (prst == 1'b0 && t_a < 0) t_a = c + 1;
            if (locked == 1'b1 && t_b < 0) t_b = c + 1;
        end
        check_obs(t_a); check_obs(t_b); check_obs(int'(retry_cnt));

        // enable low while locked
        expect_val("dis_locked", 0); expect_val("dis_prst", 1); expect_val("dis_state", 0);
        enable = 1'b0;
        step();
        check_obs(int'(locked)); check_obs(int'(prst)); check_obs(int'(state));

        // error has priority over success in ALIGN
        pvld = 3'b000; prdy = 3'b000; enable = 1'b1;
        expect_val("ep_align", 2);
        repeat (5) step();
        check_obs(int'(state));
        expect_val("ep_state", 1); expect_val("ep_retry", 1);
        pvld = 3'b111; palignerr = 3'b100;
        step();
        check_obs(int'(state)); check_obs(int'(retry_cnt));

        // bond glitch at stable count 6
        palignerr = 3'b000;
        expect_val("bg_enter_bond", 5);
        t_a = -1;
        for (int c = 0; c < 20 && t_a < 0; c++) begin
            step();
            if (state == 3'd3) t_a = c + 1;
        end
        check_obs(t_a);
        prdy = 3'b111;
        repeat (6) step();
        prdy = 3'b000;
        step();
        prdy = 3'b111;
        expect_val("bg_relock_delay", 8); expect_val("bg_retry", 1);
        t_b = -1;
        for (int c = 0; c < 20 && t_b < 0; c++) begin
            step();
            if (locked == 1'b1) t_b = c + 1;
        end
        check_obs(t_b); check_obs(int'(retry_cnt));

        // 3-cycle vde mismatch is tolerated
        expect_val("vde3_pulses", 0); expect_val("vde3_locked", 1);
        t_a = n_lost_hi;
        pvde = 3'b101;
        repeat (3) step();
        pvde = 3'b000;
        repeat (3) step();
        check_obs(n_lost_hi - t_a); check_obs(int'(locked));

        // 4-cycle vde mismatch drops lock, then relock
        expect_val("vde4_delay", 4); expect_val("vde4_locked_low", 0);
        expect_val("vde4_prst", 1); expect_val("vde4_retry", 0);
        t_a = n_lost_hi; t_b = -1;
        pvde = 3'b101;
        for (int c = 0; c < 10 && t_b < 0; c++) begin
            step();
            if (lock_lost == 1'b1) t_b = c + 1;
        end
        pvde = 3'b000;
        check_obs(t_b); check_obs(int'(locked)); check_obs(int'(prst));
        check_obs(int'(retry_cnt));
        expect_val("vde4_relock", 13); expect_val("vde4_pulses", 1);
        t_c = -1;
        for (int c = 0; c < 40 && t_c < 0; c++) begin
            step();
            if (locked == 1'b1) t_c = c + 1;
        end
        check_obs(t_c); check_obs(n_lost_hi - t_a);

        // repeated ALIGN timeouts lead to FAIL
        enable = 1'b0;
        step();
        pvld = 3'b011; prdy = 3'b000; enable = 1'b1;
        expect_val("to_retry1", 105); expect_val("to_retry2", 209);
        expect_val("to_retry3", 313); expect_val("to_fail", 313);
        expect_val("to_prst", 1); expect_val("to_state", 5);
        t_a = -1; t_b = -1; t_c = -1; t_d = -1;
        for (int c = 0; c < 400 && t_d < 0; c++) begin
            step();
            if (retry_cnt == 4'd1 && t_a < 0) t_a = c + 1;
            if (retry_cnt == 4'd2 && t_b < 0) t_b = c + 1;
            if (retry_cnt == 4'd3 && t_c < 0) t_c = c + 1;
            if (fail == 1'b1) t_d = c + 1;
        end
        check_obs(t_a); check_obs(t_b); check_obs(t_c); check_obs(t_d);
        check_obs(int'(prst)); check_obs(int'(state));

        // FAIL holds, then enable low returns to IDLE
        expect_val("fail_hold", 1);
        repeat (5) step();
        check_obs(int'(fail));
        expect_val("fx_fail", 0); expect_val("fx_state", 0); expect_val("fx_prst", 1);
        enable = 1'b0;
        step();
        check_obs(int'(fail)); check_obs(int'(state)); check_obs(int'(prst));

        // asynchronous reset while in BOND
        pvld = 3'b111; prdy = 3'b000; enable = 1'b1;
        expect_val("ar_bond", 6);
        t_a = -1;
        for (int c = 0; c < 20 && t_a < 0; c++) begin
            step();
            if (state == 3'd3) t_a = c + 1;
        end
        check_obs(t_a);
        expect_val("ar_state", 0); expect_val("ar_prst", 1); expect_val("ar_retry", 0);
        #2 arst = 1'b1;
        #1;
        check_obs(int'(state)); check_obs(int'(prst)); check_obs(int'(retry_cnt));
        expect_val("ar_release_idle", 0); expect_val("ar_then_reset", 1);
        #1 arst = 1'b0;
        #1;
        check_obs(int'(state));
        step();
        check_obs(int'(state));

        // locked, fail and lock_lost never overlap
        expect_val("exclusive", 0);
        check_obs(n_excl);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
